// File: rtl/regfile_bist_pkg.sv
// Shared types, constants and the march pattern/expectation helpers for regfile_bist.
// Optional feature macro: REGFILE_BIST_R0_ZERO_EN (register 0 expected to read as zero).
package regfile_bist_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int ERR_W  = 16;

  localparam logic [DATA_W-1:0] PAT0  = 32'h5555_5555;
  localparam logic [ADDR_W-1:0] A_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE0 = 3'd1,
    ST_READ0  = 3'd2,
    ST_WRITE1 = 3'd3,
    ST_READ1  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  // Data written at addr during a write phase; inv selects the complement pass.
  function automatic logic [DATA_W-1:0] pattern(input logic inv, input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] p;
    p = PAT0 ^ {{(DATA_W-ADDR_W){1'b0}}, addr};
    return inv ? ~p : p;
  endfunction

  // Data a healthy register file must return for addr during a read phase.
  function automatic logic [DATA_W-1:0] expected(input logic inv, input logic [ADDR_W-1:0] addr);
`ifdef REGFILE_BIST_R0_ZERO_EN
    if (addr == '0) return '0;
`endif
    return pattern(inv, addr);
  endfunction

endpackage

// File: rtl/regfile_bist_checker.sv
// Two-port read-data comparator with a saturating mismatch counter and first-failure latch.
import regfile_bist_pkg::*;

module regfile_bist_checker (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              chk_en_i,
  input  logic [DATA_W-1:0] rdata1_i,
  input  logic [DATA_W-1:0] rdata2_i,
  input  logic [DATA_W-1:0] exp1_i,
  input  logic [DATA_W-1:0] exp2_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [ADDR_W-1:0] addr2_i,
  output logic [ERR_W-1:0]  err_count_o,
  output logic [ADDR_W-1:0] fail_addr_o,
  output logic              fail_port_o
);

  logic [ERR_W-1:0]  err_q, err_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic              fail_port_q, fail_port_d;
  logic              seen_q, seen_d;
  logic              mis1, mis2;
  logic [ERR_W:0]    sum;

  assign mis1 = chk_en_i && (rdata1_i != exp1_i);
  assign mis2 = chk_en_i && (rdata2_i != exp2_i);

  always_comb begin
    sum         = {1'b0, err_q} + (ERR_W+1)'(mis1) + (ERR_W+1)'(mis2);
    err_d       = sum[ERR_W] ? '1 : sum[ERR_W-1:0];
    fail_addr_d = fail_addr_q;
    fail_port_d = fail_port_q;
    seen_d      = seen_q;
    // Port 0 wins when both ports miss on the very first failing cycle.
    if (!seen_q && (mis1 || mis2)) begin
      seen_d      = 1'b1;
      fail_addr_d = mis1 ? addr1_i : addr2_i;
      fail_port_d = !mis1;
    end
    if (clear_i) begin
      err_d       = '0;
      fail_addr_d = '0;
      fail_port_d = 1'b0;
      seen_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q       <= '0;
      fail_addr_q <= '0;
      fail_port_q <= 1'b0;
      seen_q      <= 1'b0;
    end else begin
      err_q       <= err_d;
      fail_addr_q <= fail_addr_d;
      fail_port_q <= fail_port_d;
      seen_q      <= seen_d;
    end
  end

  assign err_count_o = err_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_port_o = fail_port_q;

endmodule

// File: rtl/regfile_bist.sv
// March BIST controller for the 32x32 2R1W register file (write, verify, write ~, verify).
// Optional feature macro: REGFILE_BIST_R0_ZERO_EN (register 0 hardwired to zero).
import regfile_bist_pkg::*;

module regfile_bist (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic              fail_port,
  output logic              we,
  output logic [ADDR_W-1:0] writeaddr,
  output logic [DATA_W-1:0] writedata,
  output logic [ADDR_W-1:0] readaddr1,
  output logic [ADDR_W-1:0] readaddr2,
  input  logic [DATA_W-1:0] readdata1,
  input  logic [DATA_W-1:0] readdata2,
  output state_t            dbg_state
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic              start_acc;
  logic              chk_en;
  logic              inv;
  logic [DATA_W-1:0] exp1, exp2;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
    end
  end

  // Address sweeps up in phases 0/1 and down in phases 2/3.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    start_acc = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_WRITE0;
          a_d       = '0;
          start_acc = 1'b1;
        end
      end
      ST_WRITE0: begin
        if (a_q == A_MAX) begin
          state_d = ST_READ0;
          a_d     = '0;
        end else begin
          a_d = a_q + 1'b1;
        end
      end
      ST_READ0: begin
        if (a_q == A_MAX) begin
          state_d = ST_WRITE1;
          a_d     = A_MAX;
        end else begin
          a_d = a_q + 1'b1;
        end
      end
      ST_WRITE1: begin
        if (a_q == '0) begin
          state_d = ST_READ1;
          a_d     = A_MAX;
        end else begin
          a_d = a_q - 1'b1;
        end
      end
      ST_READ1: begin
        if (a_q == '0) state_d = ST_DONE;
        else           a_d     = a_q - 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        a_d     = '0;
      end
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    we        = 1'b0;
    writeaddr = '0;
    writedata = '0;
    readaddr1 = '0;
    readaddr2 = '0;
    chk_en    = 1'b0;
    inv       = (state_q == ST_WRITE1) || (state_q == ST_READ1);
    case (state_q)
      ST_WRITE0, ST_WRITE1: begin
        busy      = 1'b1;
        we        = 1'b1;
        writeaddr = a_q;
        writedata = pattern(inv, a_q);
      end
      ST_READ0, ST_READ1: begin
        busy      = 1'b1;
        chk_en    = 1'b1;
        readaddr1 = a_q;
        readaddr2 = ~a_q;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign exp1      = expected(inv, readaddr1);
  assign exp2      = expected(inv, readaddr2);
  assign pass      = done && (err_count == '0);
  assign dbg_state = state_q;

  regfile_bist_checker u_checker (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (start_acc),
    .chk_en_i    (chk_en),
    .rdata1_i    (readdata1),
    .rdata2_i    (readdata2),
    .exp1_i      (exp1),
    .exp2_i      (exp2),
    .addr1_i     (readaddr1),
    .addr2_i     (readaddr2),
    .err_count_o (err_count),
    .fail_addr_o (fail_addr),
    .fail_port_o (fail_port)
  );

endmodule

// File: tb/tb_regfile_bist.sv
// Bench for regfile_bist: register-file model with injectable read faults and a march-level reference.
import regfile_bist_pkg::*;

module tb_regfile_bist;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              busy, done, pass, fail_port, we;
  logic [15:0]       err_count;
  logic [4:0]        fail_addr, writeaddr, readaddr1, readaddr2;
  logic [31:0]       writedata, readdata1, readdata2;
  state_t            dbg_state;

  int                tests = 0;
  int                fails = 0;

  // Fault modes: 0 none, 1 single stuck bit, 2 r0 hardwired zero, 3 all reads zero.
  int                mode  = 0;
  int                f_reg = 0;
  int                f_bit = 0;
  logic              f_val = 1'b0;
  logic [31:0]       mem [32];

  always #5 clk = ~clk;

  regfile_bist dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_addr (fail_addr),
    .fail_port (fail_port),
    .we        (we),
    .writeaddr (writeaddr),
    .writedata (writedata),
    .readaddr1 (readaddr1),
    .readaddr2 (readaddr2),
    .readdata1 (readdata1),
    .readdata2 (readdata2),
    .dbg_state (dbg_state)
  );

  function automatic logic [31:0] fault_rd(input int md, input int fr, input int fb, input logic fv,
                                           input logic [4:0] addr, input logic [31:0] stored);
    logic [31:0] v;
    v = stored;
    case (md)
      1: if (int'(addr) == fr) v[fb] = fv;
      2: if (addr == 5'd0) v = '0;
      3: v = '0;
      default: ;
    endcase
    return v;
  endfunction

  always @(posedge clk) if (we) mem[writeaddr] <= writedata;
  assign readdata1 = fault_rd(mode, f_reg, f_bit, f_val, readaddr1, mem[readaddr1]);
  assign readdata2 = fault_rd(mode, f_reg, f_bit, f_val, readaddr2, mem[readaddr2]);

  function automatic logic [31:0] ref_pat(input int phase, input int r);
    logic [31:0] p;
    p = 32'h5555_5555 ^ r;
    return (phase == 0) ? p : ~p;
  endfunction

  // Walk both verify passes in march order and score each port read.
  task automatic ref_model(output int e_cnt, output int e_addr, output int e_port);
    int a, r;
    logic [31:0] got, want;
    e_cnt = 0; e_addr = 0; e_port = 0;
    for (int ph = 0; ph < 2; ph++) begin
      for (int k = 0; k < 32; k++) begin
        a = (ph == 0) ? k : 31 - k;
        for (int port = 0; port < 2; port++) begin
          r    = (port == 0) ? a : 31 - a;
          got  = fault_rd(mode, f_reg, f_bit, f_val, 5'(r), ref_pat(ph, r));
          want = ref_pat(ph, r);
`ifdef REGFILE_BIST_R0_ZERO_EN
          if (r == 0) want = '0;
`endif
          if (got != want) begin
            if (e_cnt == 0) begin
              e_addr = r;
              e_port = port;
            end
            if (e_cnt < 65535) e_cnt++;
          end
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic do_run(input int pulse_at, input string tag);
    int cyc, e_cnt, e_addr, e_port;
    ref_model(e_cnt, e_addr, e_port);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "/busy_after_start"}, 32'(busy), 32'd1);
    check({tag, "/done_cleared"}, 32'(done), 32'd0);
    check({tag, "/err_cleared"}, 32'(err_count), 32'd0);
    cyc = 0;
    while (!done && cyc < 300) begin
      start = (cyc + 1 == pulse_at);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check({tag, "/latency"}, 32'(cyc), 32'd128);
    check({tag, "/busy_end"}, 32'(busy), 32'd0);
    check({tag, "/err_count"}, 32'(err_count), 32'(e_cnt));
    check({tag, "/pass"}, 32'(pass), 32'(e_cnt == 0));
    check({tag, "/fail_addr"}, 32'(fail_addr), 32'(e_addr));
    check({tag, "/fail_port"}, 32'(fail_port), 32'(e_port));
  endtask

  initial begin
    int bad, gap;
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst/busy", 32'(busy), 32'd0);
    check("rst/done", 32'(done), 32'd0);
    check("rst/pass", 32'(pass), 32'd0);
    check("rst/err", 32'(err_count), 32'd0);
    check("rst/fail_addr", 32'(fail_addr), 32'd0);
    check("rst/fail_port", 32'(fail_port), 32'd0);
    check("rst/we", 32'(we), 32'd0);
    check("rst/writeaddr", 32'(writeaddr), 32'd0);
    check("rst/writedata", writedata, 32'd0);
    check("rst/readaddr1", 32'(readaddr1), 32'd0);
    check("rst/readaddr2", 32'(readaddr2), 32'd0);
    check("rst/state", 32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle/busy", 32'(busy), 32'd0);

    mode = 0;
    do_run(0, "clean");
    bad = 0;
    for (int r = 0; r < 32; r++) if (mem[r] !== ref_pat(1, r)) bad++;
    check("clean/final_contents", 32'(bad), 32'd0);

    mode = 1; f_reg = 7; f_bit = 3; f_val = 1'b1;
    do_run(0, "r7b3_sa1");

    mode = 2;
    do_run(0, "r0_zero");

    mode = 0;
    do_run(40, "start_ignored");

    mode = 3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (49) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst/we", 32'(we), 32'd0);
    check("midrst/busy", 32'(busy), 32'd0);
    check("midrst/done", 32'(done), 32'd0);
    check("midrst/err", 32'(err_count), 32'd0);
    check("midrst/state", 32'(dbg_state), 32'(ST_IDLE));
    mode = 0;
    do_run(0, "after_reset");

    mode = 3;
    do_run(0, "all_zero_a");
    do_run(0, "all_zero_b");

    for (int i = 0; i < 6; i++) begin
      mode  = 1;
      f_reg = $urandom_range(0, 31);
      f_bit = $urandom_range(0, 31);
      f_val = 1'($urandom_range(0, 1));
      gap   = $urandom_range(0, 5);
      repeat (gap) @(posedge clk);
      #1;
      do_run(0, $sformatf("rand%0d_r%0d_b%0d_v%0d", i, f_reg, f_bit, f_val));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
